// File: rtl/tron_dir_decoder.sv
// tron_dir_decoder
// Turns the PS/2 set-2 scan-code stream from the keyboard receiver into
// per-player steering directions for TRON. A small prefix FSM separates
// make codes from break (F0) and extended (E0) sequences. WASD steers
// player 1. The extended arrow keys steer player 2. Enter raises a one-cycle
// start pulse. Each player holds a pending request that is committed on the
// game tick. A request that would reverse the committed heading is rejected.
//
// Direction encoding: 00 up, 01 right, 10 down, 11 left; reverse(d) = d ^ 2'b10.

module tron_dir_decoder #(
    parameter logic [1:0] P1_INIT_DIR = 2'b01,
    parameter logic [1:0] P2_INIT_DIR = 2'b11
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] scan_code,
    input  logic       scan_code_ready,
    input  logic       tick,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic [1:0] dir_changed,
    output logic       start_pulse
);

    // ------------------------------------------------------------------
    // Scan-code constants (PS/2 set 2)
    // ------------------------------------------------------------------
    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_ENTER  = 8'h5A;

    localparam logic [7:0] CODE_W      = 8'h1D;
    localparam logic [7:0] CODE_D      = 8'h23;
    localparam logic [7:0] CODE_S      = 8'h1B;
    localparam logic [7:0] CODE_A      = 8'h1C;

    localparam logic [7:0] CODE_UP     = 8'h75;
    localparam logic [7:0] CODE_RIGHT  = 8'h74;
    localparam logic [7:0] CODE_DOWN   = 8'h72;
    localparam logic [7:0] CODE_LEFT   = 8'h6B;

    localparam logic [1:0] DIR_UP      = 2'b00;
    localparam logic [1:0] DIR_RIGHT   = 2'b01;
    localparam logic [1:0] DIR_DOWN    = 2'b10;
    localparam logic [1:0] DIR_LEFT    = 2'b11;

    // ------------------------------------------------------------------
    // Prefix FSM states
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_BREAK     = 2'b01,
        ST_EXT       = 2'b10,
        ST_EXT_BREAK = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Opposite heading: flipping bit 1 swaps up/down and right/left.
    function automatic logic [1:0] dir_reverse(input logic [1:0] dir);
        dir_reverse = dir ^ 2'b10;
    endfunction

    // True when a normal (unprefixed) make code is one of the WASD keys.
    function automatic logic is_p1_code(input logic [7:0] code);
        case (code)
            CODE_W, CODE_D, CODE_S, CODE_A: is_p1_code = 1'b1;
            default:                        is_p1_code = 1'b0;
        endcase
    endfunction

    // Heading requested by a WASD make code (only meaningful if is_p1_code).
    function automatic logic [1:0] p1_code_dir(input logic [7:0] code);
        case (code)
            CODE_W:  p1_code_dir = DIR_UP;
            CODE_D:  p1_code_dir = DIR_RIGHT;
            CODE_S:  p1_code_dir = DIR_DOWN;
            CODE_A:  p1_code_dir = DIR_LEFT;
            default: p1_code_dir = DIR_UP;
        endcase
    endfunction

    // True when an extended (E0-prefixed) make code is an arrow key.
    function automatic logic is_p2_code(input logic [7:0] code);
        case (code)
            CODE_UP, CODE_RIGHT, CODE_DOWN, CODE_LEFT: is_p2_code = 1'b1;
            default:                                   is_p2_code = 1'b0;
        endcase
    endfunction

    // Heading requested by an arrow-key make code (only meaningful if is_p2_code).
    function automatic logic [1:0] p2_code_dir(input logic [7:0] code);
        case (code)
            CODE_UP:    p2_code_dir = DIR_UP;
            CODE_RIGHT: p2_code_dir = DIR_RIGHT;
            CODE_DOWN:  p2_code_dir = DIR_DOWN;
            CODE_LEFT:  p2_code_dir = DIR_LEFT;
            default:    p2_code_dir = DIR_UP;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     state_q,        state_d;
    logic [1:0] p1_pending_q,   p1_pending_d;
    logic [1:0] p1_commit_q,    p1_commit_d;
    logic [1:0] p2_pending_q,   p2_pending_d;
    logic [1:0] p2_commit_q,    p2_commit_d;
    logic [1:0] dir_changed_q,  dir_changed_d;
    logic       start_pulse_q,  start_pulse_d;

    // Decode strobes, valid only in the cycle the byte arrives.
    logic       normal_make_s;
    logic       ext_make_s;
    logic       p1_req_vld_s;
    logic [1:0] p1_req_dir_s;
    logic       p2_req_vld_s;
    logic [1:0] p2_req_dir_s;
    logic       start_req_s;
    logic       p1_accept_s;
    logic       p2_accept_s;

    // Prefix FSM next state; flags which bytes are real make codes.
    always_comb begin
        state_d       = state_q;
        normal_make_s = 1'b0;
        ext_make_s    = 1'b0;
        if (scan_code_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == CODE_BREAK) begin
                        state_d = ST_BREAK;
                    end else if (scan_code == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d       = ST_IDLE;
                        normal_make_s = 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Key release: byte is consumed and dropped.
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (scan_code == CODE_BREAK) begin
                        state_d = ST_EXT_BREAK;
                    end else if (scan_code == CODE_EXT) begin
                        // Repeated E0 keeps the extended prefix alive.
                        state_d = ST_EXT;
                    end else begin
                        state_d    = ST_IDLE;
                        ext_make_s = 1'b1;
                    end
                end
                ST_EXT_BREAK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Map make codes onto player requests and the start request.
    always_comb begin
        p1_req_vld_s = 1'b0;
        p1_req_dir_s = DIR_UP;
        p2_req_vld_s = 1'b0;
        p2_req_dir_s = DIR_UP;
        start_req_s  = 1'b0;
        if (normal_make_s) begin
            p1_req_vld_s = is_p1_code(scan_code);
            p1_req_dir_s = p1_code_dir(scan_code);
            start_req_s  = (scan_code == CODE_ENTER);
        end else if (ext_make_s) begin
            // Keypad Enter (E0 5A) is deliberately not a start key.
            p2_req_vld_s = is_p2_code(scan_code);
            p2_req_dir_s = p2_code_dir(scan_code);
        end else begin
            p1_req_vld_s = 1'b0;
            p2_req_vld_s = 1'b0;
        end
    end

    // Reversal filter, pending update and tick commit for both players.
    // A request accepted in a tick cycle goes straight through pending_d
    // into the commit, so the same-cycle case needs no special path.
    always_comb begin
        p1_accept_s   = p1_req_vld_s && (p1_req_dir_s != dir_reverse(p1_commit_q));
        p2_accept_s   = p2_req_vld_s && (p2_req_dir_s != dir_reverse(p2_commit_q));

        p1_pending_d  = p1_pending_q;
        p2_pending_d  = p2_pending_q;
        p1_commit_d   = p1_commit_q;
        p2_commit_d   = p2_commit_q;
        dir_changed_d = 2'b00;

        if (p1_accept_s) begin
            p1_pending_d = p1_req_dir_s;
        end else begin
            p1_pending_d = p1_pending_q;
        end

        if (p2_accept_s) begin
            p2_pending_d = p2_req_dir_s;
        end else begin
            p2_pending_d = p2_pending_q;
        end

        if (tick) begin
            p1_commit_d      = p1_pending_d;
            p2_commit_d      = p2_pending_d;
            dir_changed_d[0] = (p1_pending_d != p1_commit_q);
            dir_changed_d[1] = (p2_pending_d != p2_commit_q);
        end else begin
            p1_commit_d   = p1_commit_q;
            p2_commit_d   = p2_commit_q;
            dir_changed_d = 2'b00;
        end

        start_pulse_d = start_req_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            p1_pending_q  <= P1_INIT_DIR;
            p1_commit_q   <= P1_INIT_DIR;
            p2_pending_q  <= P2_INIT_DIR;
            p2_commit_q   <= P2_INIT_DIR;
            dir_changed_q <= 2'b00;
            start_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            p1_pending_q  <= p1_pending_d;
            p1_commit_q   <= p1_commit_d;
            p2_pending_q  <= p2_pending_d;
            p2_commit_q   <= p2_commit_d;
            dir_changed_q <= dir_changed_d;
            start_pulse_q <= start_pulse_d;
        end
    end

    assign p1_dir      = p1_commit_q;
    assign p2_dir      = p2_commit_q;
    assign dir_changed = dir_changed_q;
    assign start_pulse = start_pulse_q;

endmodule

// File: tb/tb_tron_dir_decoder.sv
// Self-checking bench for tron_dir_decoder: a table of per-cycle vectors
// with hand-computed expected outputs, followed by a few hand-written
// multi-cycle sequences.

module tb_tron_dir_decoder;

    logic       clk;
    logic       resetn;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic       tick;
    logic [1:0] p1_dir;
    logic [1:0] p2_dir;
    logic [1:0] dir_changed;
    logic       start_pulse;

    int checks_total  = 0;
    int checks_passed = 0;

    tron_dir_decoder #(
        .P1_INIT_DIR(2'b01),
        .P2_INIT_DIR(2'b11)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .scan_code      (scan_code),
        .scan_code_ready(scan_code_ready),
        .tick           (tick),
        .p1_dir         (p1_dir),
        .p2_dir         (p2_dir),
        .dir_changed    (dir_changed),
        .start_pulse    (start_pulse)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       rdy;
        logic [7:0] code;
        logic       tk;
        logic [1:0] e_p1;
        logic [1:0] e_p2;
        logic [1:0] e_dc;
        logic       e_st;
    } vec_t;

    vec_t vecs[$];

    // Append one vector: inputs held for one cycle, outputs expected after its edge.
    task automatic add(input logic rstn, input logic rdy, input logic [7:0] code,
                       input logic tk, input logic [1:0] p1, input logic [1:0] p2,
                       input logic [1:0] dc, input logic st);
        vec_t v;
        v.rstn = rstn; v.rdy = rdy; v.code = code; v.tk = tk;
        v.e_p1 = p1;   v.e_p2 = p2; v.e_dc = dc;   v.e_st = st;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic rstn, input logic rdy, input logic [7:0] code,
                        input logic tk);
        resetn          = rstn;
        scan_code_ready = rdy;
        scan_code       = code;
        tick            = tk;
        @(posedge clk);
        #1;
    endtask

    // Compare all four outputs against an expected bundle.
    task automatic check(input string name, input logic [1:0] p1, input logic [1:0] p2,
                         input logic [1:0] dc, input logic st);
        checks_total++;
        if (p1_dir === p1 && p2_dir === p2 && dir_changed === dc && start_pulse === st) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got p1=%b p2=%b dc=%b st=%b, want p1=%b p2=%b dc=%b st=%b",
                     name, p1_dir, p2_dir, dir_changed, start_pulse, p1, p2, dc, st);
        end
    endtask

    initial begin
        resetn          = 1'b0;
        scan_code_ready = 1'b0;
        scan_code       = 8'h00;
        tick            = 1'b0;

        //  rstn  rdy   code   tick  p1     p2     dc     st
        add(1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0); // reset
        add(1'b0, 1'b1, 8'h1D, 1'b1, 2'b01, 2'b11, 2'b00, 1'b0); // reset dominates inputs
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 2'b11, 2'b00, 1'b0); // tick after reset: no change
        add(1'b1, 1'b1, 8'h1D, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0); // W -> p1 pending up
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 2'b11, 2'b01, 1'b0); // tick commits up
        add(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0); // dc lasts one cycle
        add(1'b1, 1'b1, 8'hF0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0); // break prefix
        add(1'b1, 1'b1, 8'h1D, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0); // W release discarded
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 2'b11, 2'b00, 1'b0); // tick: still up
        add(1'b1, 1'b1, 8'h23, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0); // D -> pending right
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 2'b11, 2'b01, 1'b0); // commit right
        add(1'b1, 1'b1, 8'h1C, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0); // A is reverse: rejected
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 2'b11, 2'b00, 1'b0); // tick: stays right
        add(1'b1, 1'b1, 8'h1B, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0); // S -> pending down
        add(1'b1, 1'b1, 8'h1C, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0); // A vs committed right: rejected
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 2'b11, 2'b01, 1'b0); // commit down
        add(1'b1, 1'b1, 8'hE0, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0); // ext prefix
        add(1'b1, 1'b1, 8'h75, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0); // up arrow -> p2 pending up
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0); // commit p2 up
        add(1'b1, 1'b1, 8'hE0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0); // E0
        add(1'b1, 1'b1, 8'hF0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0); // F0
        add(1'b1, 1'b1, 8'h75, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0); // ext release discarded
        add(1'b1, 1'b1, 8'h75, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0); // keypad 8: ignored
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0); // tick: nothing changes
        add(1'b1, 1'b1, 8'h5A, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1); // Enter -> start pulse
        add(1'b1, 1'b0, 8'h00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0); // pulse ends
        add(1'b1, 1'b1, 8'hF0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0); // F0
        add(1'b1, 1'b1, 8'h5A, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0); // Enter release: no pulse
        add(1'b1, 1'b1, 8'hE0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0); // E0
        add(1'b1, 1'b1, 8'h5A, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0); // keypad Enter: no pulse
        add(1'b1, 1'b1, 8'h1D, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0); // W+tick vs down: rejected
        add(1'b1, 1'b1, 8'h1C, 1'b1, 2'b11, 2'b00, 2'b01, 1'b0); // A+tick: bypass to left
        add(1'b1, 1'b1, 8'h1D, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0); // W+tick: up
        add(1'b1, 1'b1, 8'h23, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0); // D+tick: right
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0); // back-to-back tick: no-op
        add(1'b1, 1'b1, 8'h1B, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0); // S -> pending down
        add(1'b1, 1'b1, 8'h23, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0); // D = committed: cancels
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0); // tick: stays right
        add(1'b1, 1'b1, 8'hE0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0); // E0
        add(1'b1, 1'b1, 8'h74, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0); // right arrow -> p2 pending
        add(1'b1, 1'b1, 8'h1D, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0); // W -> p1 pending up
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 2'b01, 2'b11, 1'b0); // both commit together
        add(1'b1, 1'b1, 8'hE0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0); // E0
        add(1'b1, 1'b1, 8'hE0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0); // E0 again: stays ext
        add(1'b1, 1'b1, 8'h72, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0); // down arrow -> p2 pending
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 2'b10, 2'b10, 1'b0); // commit p2 down
        add(1'b1, 1'b1, 8'hE0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0); // E0, then reset
        add(1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0); // reset mid-sequence
        add(1'b1, 1'b1, 8'h75, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0); // 75 now non-extended
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 2'b11, 2'b00, 1'b0); // tick: p2 unchanged
        add(1'b1, 1'b0, 8'h1D, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0); // code without ready
        add(1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 2'b11, 2'b00, 1'b0); // tick: ignored

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rstn, vecs[i].rdy, vecs[i].code, vecs[i].tk);
            check($sformatf("vec%0d", i), vecs[i].e_p1, vecs[i].e_p2, vecs[i].e_dc, vecs[i].e_st);
        end

        // Typematic repeats of W are ordinary make codes; pending stays up.
        step(1'b1, 1'b1, 8'h1D, 1'b0);
        step(1'b1, 1'b1, 8'h1D, 1'b0);
        step(1'b1, 1'b1, 8'h1D, 1'b0);
        check("typematic_hold", 2'b01, 2'b11, 2'b00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("typematic_commit", 2'b00, 2'b11, 2'b01, 1'b0);

        // A single Enter pulses once and never stretches over idle cycles.
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        check("start_pulse_hi", 2'b00, 2'b11, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 8'h5A, 1'b0);
            check($sformatf("start_pulse_lo%0d", k), 2'b00, 2'b11, 2'b00, 1'b0);
        end

        // Two Enter bytes back-to-back give two consecutive pulse cycles.
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        check("start_b2b_0", 2'b00, 2'b11, 2'b00, 1'b1);
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        check("start_b2b_1", 2'b00, 2'b11, 2'b00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("start_b2b_end", 2'b00, 2'b11, 2'b00, 1'b0);

        // Extended request in the tick cycle bypasses pending for player 2.
        step(1'b1, 1'b1, 8'hE0, 1'b0);
        step(1'b1, 1'b1, 8'h75, 1'b1);
        check("p2_bypass", 2'b00, 2'b00, 2'b10, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("p2_bypass_hold", 2'b00, 2'b00, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
